uart_rx_if: RTL and testbench

Receive-side command interface: consumes bytes delivered by the UART byte receiver and assembles two-byte command packets (high byte first, then low byte) into a CMD_PKT_LEN-bit command for the register/command logic. It mirrors the transmit-side interface, which splits a command into the same two bytes on the wire. The block adds an inter-byte timeout, error abort and a one-entry output register with a valid/ready handshake.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_bit_timer.sv | 30 +++
 rtl/uart_rx_if.sv | 145 ++++++++++++++
 tb/tb_uart_rx_if.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART command interfaces: default widths,
// bit-period arithmetic, assembly state encoding and command field layout.
package uart_pkg;

    localparam int DATA_WIDTH_DEF  = 8;
    localparam int CMD_PKT_LEN_DEF = 2 * DATA_WIDTH_DEF;

    // Assembly FSM encoding; two bits so the unused codes recover to IDLE.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT_LO = 2'd1;

    // Command field positions within the assembled command word.
    localparam int CMD_RW_BIT    = 15;
    localparam int CMD_ADDR_MSB  = 14;
    localparam int CMD_ADDR_LSB  = 8;
    localparam int CMD_DATA_MSB  = 7;
    localparam int CMD_DATA_LSB  = 0;

    // System clocks per line bit, truncated.
    function automatic int cycles_per_bit(input int sys_clk_freq, input int bps);
        return sys_clk_freq / bps;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Clearable, enabled 32-bit counter with a terminal-count flag at LIMIT-1.
// Shared by the receive and transmit command interfaces.
module uart_bit_timer #(
    parameter int LIMIT = 8680
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    output logic [31:0] count,
    output logic        tc
);

    // Count up while enabled; clear has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 32'd0;
        end else if (clr) begin
            count <= 32'd0;
        end else if (en) begin
            count <= count + 32'd1;
        end
    end

    // Terminal count is reached on the last cycle of the interval.
    always_comb begin
        tc = (count == 32'(LIMIT - 1));
    end

endmodule

// File: rtl/uart_rx_if.sv
// Receive-side command interface: pairs received bytes (high then low) into
// a command word, aborting on a bad byte or an inter-byte timeout, and hands
// the result to the consumer through a one-entry valid/ready output stage.
//
// Handshake: cmd_valid/cmd_ready; a transfer happens on any clock edge where
// both are high. While cmd_valid is high and cmd_ready is low, cmd is held.
// Reception never stalls: a packet completing into a full stage is dropped
// and flagged with overflow.
module uart_rx_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int CMD_PKT_LEN  = CMD_PKT_LEN_DEF,
    parameter int BPS          = 115_200,
    parameter int SYS_CLK_FREQ = 50_000_000,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  rx_data,
    input  logic                   rx_done,
    input  logic                   rx_err,
    output logic [CMD_PKT_LEN-1:0] cmd,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic                   busy,
    output logic                   pkt_drop,
    output logic                   timeout,
    output logic                   overflow
);

    localparam int CYCLES_PER_BIT = cycles_per_bit(SYS_CLK_FREQ, BPS);
    localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CYCLES_PER_BIT;

    logic [1:0]             state;
    logic [1:0]             state_n;
    logic [DATA_WIDTH-1:0]  hi_byte;
    logic                   hi_load;
    logic                   complete;
    logic                   drop_n;
    logic                   timeout_n;
    logic                   timer_clr;
    logic                   timer_en;
    logic                   timer_tc;
    logic [31:0]            timer_count;
    logic                   good_byte;
    logic                   bad_byte;
    logic                   xfer;

    assign good_byte = rx_done & ~rx_err;
    assign bad_byte  = rx_done &  rx_err;
    assign xfer      = cmd_valid & cmd_ready;

    uart_bit_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (timer_clr),
        .en    (timer_en),
        .count (timer_count),
        .tc    (timer_tc)
    );

    // Assembly decisions: a received byte always takes priority over expiry.
    always_comb begin
        state_n   = state;
        hi_load   = 1'b0;
        complete  = 1'b0;
        drop_n    = 1'b0;
        timeout_n = 1'b0;
        timer_clr = 1'b0;
        timer_en  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (good_byte) begin
                    hi_load   = 1'b1;
                    timer_clr = 1'b1;
                    state_n   = ST_WAIT_LO;
                end else if (bad_byte) begin
                    drop_n = 1'b1;
                end
            end
            ST_WAIT_LO: begin
                if (good_byte) begin
                    complete = 1'b1;
                    state_n  = ST_IDLE;
                end else if (bad_byte) begin
                    drop_n  = 1'b1;
                    state_n = ST_IDLE;
                end else if (timer_tc) begin
                    timeout_n = 1'b1;
                    state_n   = ST_IDLE;
                end else begin
                    timer_en = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Assembly state, held high byte and registered busy/status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            hi_byte  <= '0;
            busy     <= 1'b0;
            pkt_drop <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_n;
            busy     <= (state_n == ST_WAIT_LO);
            pkt_drop <= drop_n;
            timeout  <= timeout_n;
            if (hi_load) begin
                hi_byte <= rx_data;
            end
        end
    end

    // One-entry output stage: load when empty or draining this cycle,
    // otherwise discard the new packet and flag overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd       <= '0;
            cmd_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (complete) begin
                if (!cmd_valid || xfer) begin
                    cmd       <= {hi_byte, rx_data};
                    cmd_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (xfer) begin
                cmd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_if.sv
// Bench for uart_rx_if: directed vector table, hand sequences for timeout
// and reset, then randomized traffic against a packet-level reference model.
module tb_uart_rx_if;

    localparam int TC = (50_000_000 / 115_200) * 20;  // 8680 cycles

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        rx_err;
    logic [15:0] cmd;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        busy;
    logic        pkt_drop;
    logic        timeout;
    logic        overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] exp_q[$];

    uart_rx_if dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .rx_err    (rx_err),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .busy      (busy),
        .pkt_drop  (pkt_drop),
        .timeout   (timeout),
        .overflow  (overflow)
    );

    // Clock
    always #5 clk = ~clk;

    typedef struct {
        logic        done;
        logic        err;
        logic [7:0]  data;
        logic        rdy;
        logic [15:0] e_cmd;
        logic        e_v;
        logic        e_b;
        logic        e_d;
        logic        e_t;
        logic        e_o;
    } vec_t;

    vec_t tbl[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] outs();
        return {11'd0, cmd, cmd_valid, busy, pkt_drop, timeout, overflow};
    endfunction

    function automatic logic [31:0] mk(input logic [15:0] c, input logic v, input logic b,
                                       input logic d, input logic t, input logic o);
        return {11'd0, c, v, b, d, t, o};
    endfunction

    // Driver: apply inputs for one cycle, return #1 after the edge.
    task automatic cycle(input logic d, input logic e, input logic [7:0] data, input logic rdy);
        rx_done   = d;
        rx_err    = e;
        rx_data   = data;
        cmd_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        rx_done   = 1'b0;
        rx_err    = 1'b0;
        rx_data   = 8'h00;
        cmd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", outs(), 32'd0);
        rst = 1'b0;
    endtask

    // Reference model state (packet level, cycle-indexed)
    logic        m_have_hi;
    logic [7:0]  m_hi;
    int          m_hi_cyc;
    logic        m_valid;
    logic [15:0] m_cmd;
    logic        m_drop, m_to, m_ovf;

    task automatic model_step(input int cyc, input logic d, input logic e,
                              input logic [7:0] data, input logic rdy);
        logic        xf;
        logic        done_pkt;
        logic [15:0] new_cmd;
        xf       = m_valid && rdy;
        done_pkt = 1'b0;
        new_cmd  = 16'h0;
        m_drop   = 1'b0;
        m_to     = 1'b0;
        m_ovf    = 1'b0;
        if (d) begin
            if (e) begin
                m_drop    = 1'b1;
                m_have_hi = 1'b0;
            end else if (m_have_hi) begin
                done_pkt  = 1'b1;
                new_cmd   = {m_hi, data};
                m_have_hi = 1'b0;
            end else begin
                m_have_hi = 1'b1;
                m_hi      = data;
                m_hi_cyc  = cyc;
            end
        end else if (m_have_hi && (cyc - m_hi_cyc == TC)) begin
            m_to      = 1'b1;
            m_have_hi = 1'b0;
        end
        if (done_pkt) begin
            if (!m_valid || xf) begin
                m_cmd   = new_cmd;
                m_valid = 1'b1;
                exp_q.push_back(new_cmd);
            end else begin
                m_ovf = 1'b1;
            end
        end else if (xf) begin
            m_valid = 1'b0;
        end
    endtask

    initial begin
        int          k;
        logic        prev_busy;
        logic        d, e, r;
        logic [7:0]  data;
        int          quiet;

        // Directed table: inputs for one cycle, outputs expected after the edge.
        tbl[0]  = '{1'b1, 1'b0, 8'h85, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 8'h3C, 1'b1, 16'h853C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 16'h853C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 8'hAA, 1'b1, 16'h853C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 8'h00, 1'b1, 16'h853C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 8'h01, 1'b1, 16'h853C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 8'h02, 1'b0, 16'h0102, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 16'h0102, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 8'h11, 1'b0, 16'h0102, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 8'h11, 1'b0, 16'h1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 8'h22, 1'b0, 16'h1111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 8'h22, 1'b0, 16'h1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 16'h1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 8'h11, 1'b0, 16'h1111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 8'h11, 1'b0, 16'h1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{1'b1, 1'b0, 8'h33, 1'b0, 16'h1111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[18] = '{1'b1, 1'b0, 8'h44, 1'b1, 16'h3344, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 1'b0, 8'h00, 1'b0, 16'h3344, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 1'b0, 8'h00, 1'b1, 16'h3344, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        do_reset();

        for (int i = 0; i < 21; i++) begin
            cycle(tbl[i].done, tbl[i].err, tbl[i].data, tbl[i].rdy);
            check($sformatf("table_row_%0d", i), outs(),
                  mk(tbl[i].e_cmd, tbl[i].e_v, tbl[i].e_b, tbl[i].e_d, tbl[i].e_t, tbl[i].e_o));
        end

        // Timeout: high byte then silence; pulse exactly TC+1 cycles later.
        cycle(1'b1, 1'b0, 8'h12, 1'b1);
        k = 1;
        check("to_busy_start", {31'd0, busy}, 32'd1);
        prev_busy = busy;
        while (!timeout && k < TC + 100) begin
            prev_busy = busy;
            cycle(1'b0, 1'b0, 8'h00, 1'b1);
            k++;
        end
        check("to_latency", k, TC + 1);
        check("to_busy_before", {31'd0, prev_busy}, 32'd1);
        check("to_busy_after", {31'd0, busy}, 32'd0);
        check("to_no_valid", {31'd0, cmd_valid}, 32'd0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("to_single_pulse", {31'd0, timeout}, 32'd0);

        // Low byte in the cycle the timer expires: byte wins.
        cycle(1'b1, 1'b0, 8'h12, 1'b1);
        repeat (TC - 1) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("edge_still_busy", outs(), mk(16'h3344, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        cycle(1'b1, 1'b0, 8'h34, 1'b1);
        check("edge_byte_wins", outs(), mk(16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("edge_no_late_to", outs(), mk(16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        // Reset mid-packet with a held command.
        cycle(1'b1, 1'b0, 8'h55, 1'b0);
        cycle(1'b1, 1'b0, 8'h66, 1'b0);
        cycle(1'b1, 1'b0, 8'h77, 1'b0);
        check("pre_rst_state", outs(), mk(16'h5566, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_clears", outs(), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1'b1, 1'b0, 8'h0F, 1'b1);
        cycle(1'b1, 1'b0, 8'h0F, 1'b1);
        check("post_rst_pkt", outs(), mk(16'h0F0F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

        // Randomized traffic against the reference model.
        do_reset();
        m_have_hi = 1'b0;
        m_hi      = 8'h00;
        m_hi_cyc  = 0;
        m_valid   = 1'b0;
        m_cmd     = 16'h0;
        m_drop    = 1'b0;
        m_to      = 1'b0;
        m_ovf     = 1'b0;
        exp_q.delete();
        quiet = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) quiet = TC + 10;
            d    = ($urandom_range(0, 99) < 40);
            e    = ($urandom_range(0, 99) < 10);
            data = 8'($urandom_range(0, 255));
            r    = ($urandom_range(0, 99) < 60);
            if (quiet > 0) begin
                d = 1'b0;
                quiet--;
            end
            if (m_valid && r) begin
                if (exp_q.size() == 0) begin
                    check("sb_queue_empty", 32'd0, 32'd1);
                end else begin
                    check("sb_transfer", {16'd0, cmd}, {16'd0, exp_q.pop_front()});
                end
            end
            model_step(c, d, e, data, r);
            cycle(d, e, data, r);
            check("rand_outputs", outs(), mk(m_cmd, m_valid, m_have_hi, m_drop, m_to, m_ovf));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
